// File: rtl/sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : sprite_animator
// Brief    : Raster-to-ROM address mapping, per-frame animation sequencing and
//            two-stage compositing of the sprite pixel over the background.
// Revision : 1.0  initial release
// ============================================================================
module sprite_animator #(
  parameter int          WIDTH       = 40,
  parameter int          HEIGHT      = 20,
  parameter int          LOG_FRAMES  = 3,
  parameter int          NUM_FRAMES  = 8,
  parameter int          FRAME_DIV   = 4,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [10:0]           hcount,
  input  logic [9:0]            vcount,
  input  logic                  vsync,
  input  logic [10:0]           sprite_x,
  input  logic [9:0]            sprite_y,
  input  logic [2:0]            s_type_in,
  input  logic                  anim_en,
  input  logic                  pingpong,
  input  logic [11:0]           bg_pixel,
  output logic [5:0]            rom_x,
  output logic [4:0]            rom_y,
  output logic [LOG_FRAMES-1:0] rom_frame,
  output logic [2:0]            rom_s_type,
  input  logic [11:0]           rom_pixel,
  output logic [11:0]           pixel_out,
  output logic                  in_sprite
);

  localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [DIV_W-1:0]      C_DIV_LAST     = DIV_W'(FRAME_DIV - 1);
  localparam logic [LOG_FRAMES-1:0] C_FRAME_LAST   = LOG_FRAMES'(NUM_FRAMES - 1);
  localparam logic [LOG_FRAMES-1:0] C_FRAME_PENULT = LOG_FRAMES'(NUM_FRAMES - 2);
  localparam logic [LOG_FRAMES-1:0] C_FRAME_ONE    = LOG_FRAMES'(1);
  localparam logic [11:0]           C_WIDTH        = 12'(WIDTH);
  localparam logic [10:0]           C_HEIGHT       = 11'(HEIGHT);

  typedef enum logic [0:0] {
    FWD = 1'b0,
    REV = 1'b1
  } anim_state_t;

  logic                  vsync_q, vsync_d;
  logic                  frame_start;
  logic [10:0]           sprite_x_q, sprite_x_d;
  logic [9:0]            sprite_y_q, sprite_y_d;
  logic [2:0]            s_type_q, s_type_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [LOG_FRAMES-1:0] frame_q, frame_d;
  anim_state_t           state_q, state_d;
  logic                  step;

  logic [11:0]           dx;
  logic [10:0]           dy;
  logic [5:0]            rom_x_q, rom_x_d;
  logic [4:0]            rom_y_q, rom_y_d;
  logic                  inbox_q, inbox_d;
  logic [11:0]           bg_q, bg_d;
  logic                  opaque;
  logic [11:0]           pixel_q, pixel_d;
  logic                  in_sprite_q, in_sprite_d;

  // Falling edge of vsync, observed one pixel clock late.
  assign frame_start = vsync_q & ~vsync;

  always_comb begin
    vsync_d    = vsync;
    sprite_x_d = sprite_x_q;
    sprite_y_d = sprite_y_q;
    s_type_d   = s_type_q;
    if (frame_start) begin
      sprite_x_d = sprite_x;
      sprite_y_d = sprite_y;
      s_type_d   = s_type_in;
    end
  end

  always_comb begin
    div_d   = div_q;
    frame_d = frame_q;
    state_d = state_q;
    step    = 1'b0;
    if (frame_start && anim_en) begin
      if (div_q == C_DIV_LAST) begin
        div_d = '0;
        step  = 1'b1;
      end else begin
        div_d = div_q + 1'b1;
      end
    end
    if (step) begin
      case (state_q)
        FWD: begin
          if (frame_q == C_FRAME_LAST) begin
            if (pingpong) begin
              frame_d = C_FRAME_PENULT;
              state_d = REV;
            end else begin
              frame_d = '0;
            end
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
        REV: begin
          // Leaving pingpong mode mid-bounce restarts the loop from frame 0.
          if (!pingpong) begin
            frame_d = '0;
            state_d = FWD;
          end else if (frame_q == '0) begin
            frame_d = C_FRAME_ONE;
            state_d = FWD;
          end else begin
            frame_d = frame_q - 1'b1;
          end
        end
        default: state_d = FWD;
      endcase
    end
  end

  always_comb begin
    dx      = {1'b0, hcount} - {1'b0, sprite_x_q};
    dy      = {1'b0, vcount} - {1'b0, sprite_y_q};
    inbox_d = !dx[11] && !dy[10] && (dx < C_WIDTH) && (dy < C_HEIGHT);
    rom_x_d = inbox_d ? dx[5:0] : 6'd0;
    rom_y_d = inbox_d ? dy[4:0] : 5'd0;
    bg_d    = bg_pixel;
  end

  always_comb begin
    opaque      = inbox_q && (rom_pixel != TRANSPARENT);
    pixel_d     = opaque ? rom_pixel : bg_q;
    in_sprite_d = opaque;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vsync_q     <= 1'b0;
      sprite_x_q  <= '0;
      sprite_y_q  <= '0;
      s_type_q    <= '0;
      div_q       <= '0;
      frame_q     <= '0;
      state_q     <= FWD;
      rom_x_q     <= '0;
      rom_y_q     <= '0;
      inbox_q     <= 1'b0;
      bg_q        <= '0;
      pixel_q     <= '0;
      in_sprite_q <= 1'b0;
    end else begin
      vsync_q     <= vsync_d;
      sprite_x_q  <= sprite_x_d;
      sprite_y_q  <= sprite_y_d;
      s_type_q    <= s_type_d;
      div_q       <= div_d;
      frame_q     <= frame_d;
      state_q     <= state_d;
      rom_x_q     <= rom_x_d;
      rom_y_q     <= rom_y_d;
      inbox_q     <= inbox_d;
      bg_q        <= bg_d;
      pixel_q     <= pixel_d;
      in_sprite_q <= in_sprite_d;
    end
  end

  assign rom_x      = rom_x_q;
  assign rom_y      = rom_y_q;
  assign rom_frame  = frame_q;
  assign rom_s_type = s_type_q;
  assign pixel_out  = pixel_q;
  assign in_sprite  = in_sprite_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_animator.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_animator
// Brief    : Directed, table-driven bench for sprite_animator.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_animator;

  logic        clock = 1'b0;
  logic        reset;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic [10:0] sprite_x;
  logic [9:0]  sprite_y;
  logic [2:0]  s_type_in;
  logic        anim_en, pingpong, anim_en_b, pingpong_b;
  logic [11:0] bg_pixel;

  logic [5:0]  rom_x, rom_x_b;
  logic [4:0]  rom_y, rom_y_b;
  logic [2:0]  rom_frame, rom_frame_b;
  logic [2:0]  rom_s_type, rom_s_type_b;
  logic [11:0] rom_pixel, rom_pixel_b;
  logic [11:0] pixel_out, pixel_out_b;
  logic        in_sprite, in_sprite_b;

  logic        rom_kind;
  logic [11:0] rom_const;

  int n_cmp = 0;
  int n_bad = 0;

  // ROM model: address pattern (never 000) or a forced constant.
  assign rom_pixel   = rom_kind ? rom_const : {rom_x, rom_y, 1'b1};
  assign rom_pixel_b = {rom_x_b, rom_y_b, 1'b1};

  always #5 clock = ~clock;

  sprite_animator dut (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .s_type_in(s_type_in),
    .anim_en(anim_en), .pingpong(pingpong), .bg_pixel(bg_pixel),
    .rom_x(rom_x), .rom_y(rom_y), .rom_frame(rom_frame), .rom_s_type(rom_s_type),
    .rom_pixel(rom_pixel), .pixel_out(pixel_out), .in_sprite(in_sprite)
  );

  sprite_animator #(.FRAME_DIV(1)) dut_b (
    .clock(clock), .reset(reset), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .s_type_in(s_type_in),
    .anim_en(anim_en_b), .pingpong(pingpong_b), .bg_pixel(bg_pixel),
    .rom_x(rom_x_b), .rom_y(rom_y_b), .rom_frame(rom_frame_b), .rom_s_type(rom_s_type_b),
    .rom_pixel(rom_pixel_b), .pixel_out(pixel_out_b), .in_sprite(in_sprite_b)
  );

  typedef struct {
    logic [10:0] sx;
    logic [9:0]  sy;
    logic [10:0] h;
    logic [9:0]  v;
    logic [11:0] bg;
    logic        kind;
    logic [11:0] rconst;
    logic [5:0]  ex;
    logic [4:0]  ey;
    logic [11:0] epix;
    logic        ein;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic vsync_fall();
    @(negedge clock) vsync = 1'b1;
    @(negedge clock) vsync = 1'b0;
    @(negedge clock);
  endtask

  // Hold one raster position for two clocks and check both pipeline stages.
  task automatic probe(input string name, input logic [10:0] h, input logic [9:0] v,
                       input logic [11:0] bg, input logic kind, input logic [11:0] rconst,
                       input logic [5:0] ex, input logic [4:0] ey,
                       input logic [11:0] epix, input logic ein);
    @(negedge clock);
    hcount = h; vcount = v; bg_pixel = bg; rom_kind = kind; rom_const = rconst;
    @(negedge clock);
    check({name, " rom_x"}, 32'(rom_x), 32'(ex));
    check({name, " rom_y"}, 32'(rom_y), 32'(ey));
    @(negedge clock);
    check({name, " pixel_out"}, 32'(pixel_out), 32'(epix));
    check({name, " in_sprite"}, 32'(in_sprite), 32'(ein));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [10:0] cur_sx;
  logic [9:0]  cur_sy;
  logic [11:0] s_exp_pix[8];
  logic        s_exp_in[8];
  int          pp_seq[25];

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; vsync = 1'b0; sprite_x = '0; sprite_y = '0;
    s_type_in = '0; anim_en = 1'b0; pingpong = 1'b0; anim_en_b = 1'b0; pingpong_b = 1'b0;
    bg_pixel = '0; rom_kind = 1'b0; rom_const = '0;

    #2;
    check("reset pixel_out", 32'(pixel_out), 32'h0);
    check("reset in_sprite", 32'(in_sprite), 32'h0);
    check("reset rom_frame", 32'(rom_frame), 32'h0);
    check("reset rom_s_type", 32'(rom_s_type), 32'h0);
    @(negedge clock);
    @(negedge clock) reset = 1'b0;

    //        sx     sy    h     v     bg    kind rconst  ex  ey  epix   ein
    vecs[0]  = '{100,  50,  100,  50, 12'h111, 0, 12'h000,  0,  0, 12'h001, 1};
    vecs[1]  = '{100,  50,  139,  69, 12'h222, 0, 12'h000, 39, 19, 12'h9E7, 1};
    vecs[2]  = '{100,  50,  140,  50, 12'hABC, 0, 12'h000,  0,  0, 12'hABC, 0};
    vecs[3]  = '{100,  50,   99,  50, 12'h123, 0, 12'h000,  0,  0, 12'h123, 0};
    vecs[4]  = '{100,  50,  100,  49, 12'h321, 0, 12'h000,  0,  0, 12'h321, 0};
    vecs[5]  = '{100,  50,  100,  70, 12'h456, 0, 12'h000,  0,  0, 12'h456, 0};
    vecs[6]  = '{100,  50,  139,  50, 12'h0F0, 0, 12'h000, 39,  0, 12'h9C1, 1};
    vecs[7]  = '{100,  50,  105,  52, 12'h888, 1, 12'h244,  5,  2, 12'h244, 1};
    vecs[8]  = '{100,  50,  110,  55, 12'h777, 1, 12'h000, 10,  5, 12'h777, 0};
    vecs[9]  = '{2030, 1000, 2047, 1005, 12'h999, 0, 12'h000, 17, 5, 12'h44B, 1};
    vecs[10] = '{2030, 1000,    5, 1005, 12'h5A5, 0, 12'h000,  0, 0, 12'h5A5, 0};
    vecs[11] = '{2030, 1000, 2029, 1005, 12'h3C3, 0, 12'h000,  0, 0, 12'h3C3, 0};
    vecs[12] = '{0,    0,      0,    0, 12'hFFF, 0, 12'h000,  0,  0, 12'h001, 1};
    vecs[13] = '{0,    0,      0,   19, 12'hEEE, 0, 12'h000,  0, 19, 12'h027, 1};

    cur_sx = '0; cur_sy = '0;
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].sx != cur_sx || vecs[i].sy != cur_sy) begin
        sprite_x = vecs[i].sx; sprite_y = vecs[i].sy;
        vsync_fall();
        cur_sx = vecs[i].sx; cur_sy = vecs[i].sy;
      end
      probe($sformatf("vec%0d", i), vecs[i].h, vecs[i].v, vecs[i].bg, vecs[i].kind,
            vecs[i].rconst, vecs[i].ex, vecs[i].ey, vecs[i].epix, vecs[i].ein);
    end

    // Streaming raster across the left edge: two-clock latency per pixel.
    sprite_x = 11'd100; sprite_y = 10'd50;
    vsync_fall();
    rom_kind = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i >= 2) begin
        check($sformatf("stream%0d pixel_out", i - 2), 32'(pixel_out), 32'(s_exp_pix[i-2]));
        check($sformatf("stream%0d in_sprite", i - 2), 32'(in_sprite), 32'(s_exp_in[i-2]));
      end
      if (i < 8) begin
        hcount = 11'(98 + i); vcount = 10'd50; bg_pixel = 12'(12'h800 + i);
        s_exp_in[i]  = (98 + i) >= 100;
        s_exp_pix[i] = s_exp_in[i] ? {6'(i - 2), 5'd0, 1'b1} : 12'(12'h800 + i);
      end
    end

    // Loop mode, one step every fourth frame.
    anim_en = 1'b1;
    for (int k = 1; k <= 44; k++) begin
      vsync_fall();
      check($sformatf("loop fall%0d rom_frame", k), 32'(rom_frame), 32'((k / 4) % 8));
    end
    anim_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      vsync_fall();
      check($sformatf("hold fall%0d rom_frame", k), 32'(rom_frame), 32'd3);
    end
    anim_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vsync_fall();
      check($sformatf("resume fall%0d rom_frame", k), 32'(rom_frame), 32'd3);
    end
    vsync_fall();
    check("resume step rom_frame", 32'(rom_frame), 32'd4);
    anim_en = 1'b0;

    // Pingpong on the FRAME_DIV=1 instance, then drop pingpong while reversing at 3.
    pp_seq = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3};
    anim_en_b = 1'b1; pingpong_b = 1'b1;
    for (int j = 0; j < 25; j++) begin
      vsync_fall();
      check($sformatf("pp fall%0d rom_frame", j), 32'(rom_frame_b), 32'(pp_seq[j]));
    end
    pingpong_b = 1'b0;
    vsync_fall();
    check("pp exit rom_frame", 32'(rom_frame_b), 32'd0);
    vsync_fall();
    check("pp exit+1 rom_frame", 32'(rom_frame_b), 32'd1);
    anim_en_b = 1'b0;
    check("loop frame held", 32'(rom_frame), 32'd4);

    // Mid-frame position/type change must wait for the next frame start.
    s_type_in = 3'd5;
    vsync_fall();
    check("s_type latched", 32'(rom_s_type), 32'd5);
    sprite_x = 11'd300; s_type_in = 3'd2;
    probe("midframe old", 11'd100, 10'd50, 12'h0AA, 1'b0, 12'h000, 6'd0, 5'd0, 12'h001, 1'b1);
    probe("midframe new", 11'd300, 10'd50, 12'h0BB, 1'b0, 12'h000, 6'd0, 5'd0, 12'h0BB, 1'b0);
    check("s_type held", 32'(rom_s_type), 32'd5);
    vsync_fall();
    check("s_type updated", 32'(rom_s_type), 32'd2);
    probe("newframe", 11'd300, 10'd50, 12'h0CC, 1'b0, 12'h000, 6'd0, 5'd0, 12'h001, 1'b1);

    // Asynchronous reset mid-line, between clock edges.
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("areset pixel_out", 32'(pixel_out), 32'h0);
    check("areset in_sprite", 32'(in_sprite), 32'h0);
    check("areset rom_frame", 32'(rom_frame), 32'h0);
    check("areset rom_x", 32'(rom_x), 32'h0);
    check("areset rom_s_type", 32'(rom_s_type), 32'h0);
    check("areset b rom_frame", 32'(rom_frame_b), 32'h0);
    check("areset b pixel_out", 32'(pixel_out_b), 32'h0);
    check("areset b in_sprite", 32'(in_sprite_b), 32'h0);
    check("areset b rom_s_type", 32'(rom_s_type_b), 32'h0);
    hcount = 11'd500; vcount = 10'd50; bg_pixel = 12'h6B6;
    @(negedge clock) reset = 1'b0;
    @(negedge clock);
    check("post-reset clk1 pixel_out", 32'(pixel_out), 32'h0);
    @(negedge clock);
    check("post-reset clk2 pixel_out", 32'(pixel_out), 32'h6B6);
    check("post-reset clk2 in_sprite", 32'(in_sprite), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
